// File: rtl/snake_engine.sv
// Snake game engine on a 16x16 grid: segment shift register, LFSR food placement and game FSM.
// Optional build macro SNAKE_WRAP_EN makes the grid edges wrap instead of ending the game.
module snake_engine #(
   parameter int unsigned WIN_LEN   = 15,
   parameter logic [7:0]  INIT_HEAD = 8'h88,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         Start,
   input  logic         BtnU,
   input  logic         BtnD,
   input  logic         BtnL,
   input  logic         BtnR,
   input  logic         Tick,
   output logic         Qi,
   output logic         Qc,
   output logic         Qw,
   output logic         Ql,
   output logic [7:0]   Food,
   output logic [3:0]   Length,
   output logic [127:0] Locations_Flat
);

`ifdef SNAKE_WRAP_EN
   localparam bit WRAP_EN = 1'b1;
`else
   localparam bit WRAP_EN = 1'b0;
`endif

   typedef enum logic [2:0] {S_INIT, S_FOOD, S_PLAY, S_WIN, S_LOSE} state_t;
   typedef enum logic [1:0] {DIR_U, DIR_D, DIR_L, DIR_R} dir_t;

   state_t     state, state_nxt;
   dir_t       dir, dir_nxt, req;
   logic       req_vld;
   logic [7:0] seg [16];
   logic [7:0] lfsr, lfsr_nxt;
   logic [7:0] next_head;
   logic [3:0] row, col;
   logic       at_edge, wall, eat, self_hit, food_hit, win;

   function automatic dir_t opposite(input dir_t d);
      case (d)
         DIR_U:   return DIR_D;
         DIR_D:   return DIR_U;
         DIR_L:   return DIR_R;
         default: return DIR_L;
      endcase
   endfunction

   assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   assign row      = seg[0][7:4];
   assign col      = seg[0][3:0];

   always_comb begin
      food_hit = 1'b0;
      for (int unsigned k = 0; k < 16; k++)
         if (k < 32'(Length) && seg[k] == lfsr_nxt) food_hit = 1'b1;
   end

   // 4-bit row/col arithmetic wraps on its own; at_edge decides whether that is a wall hit.
   always_comb begin
      next_head = seg[0];
      at_edge   = 1'b0;
      case (dir)
         DIR_U: begin next_head = {row - 4'd1, col}; at_edge = (row == 4'd0); end
         DIR_D: begin next_head = {row + 4'd1, col}; at_edge = (row == 4'hF); end
         DIR_L: begin next_head = {row, col - 4'd1}; at_edge = (col == 4'd0); end
         DIR_R: begin next_head = {row, col + 4'd1}; at_edge = (col == 4'hF); end
      endcase
   end

   assign wall = at_edge && !WRAP_EN;
   assign eat  = (next_head == Food);
   assign win  = eat && ((Length + 4'd1) == 4'(WIN_LEN));

   // The tail cell is vacated by a plain move, but stays occupied when the snake grows.
   always_comb begin
      self_hit = 1'b0;
      for (int unsigned k = 1; k < 16; k++)
         if (seg[k] == next_head &&
             ((k + 2 <= 32'(Length)) || (eat && (k + 1 == 32'(Length)))))
            self_hit = 1'b1;
   end

   always_comb begin
      req     = dir;
      req_vld = 1'b1;
      if (BtnU)      req = DIR_U;
      else if (BtnD) req = DIR_D;
      else if (BtnL) req = DIR_L;
      else if (BtnR) req = DIR_R;
      else           req_vld = 1'b0;
      dir_nxt = (req_vld && req != opposite(dir)) ? req : dir;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) state <= S_INIT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_INIT: if (Start) state_nxt = S_FOOD;
         S_FOOD: if (!food_hit) state_nxt = S_PLAY;
         S_PLAY: begin
            if (Tick) begin
               if (wall || self_hit) state_nxt = S_LOSE;
               else if (eat)         state_nxt = win ? S_WIN : S_FOOD;
            end
         end
         S_WIN, S_LOSE: if (Start) state_nxt = S_INIT;
         default: state_nxt = S_INIT;
      endcase
   end

   always_comb begin
      Qi = (state == S_INIT);
      Qc = (state == S_FOOD);
      Qw = (state == S_WIN);
      Ql = (state == S_LOSE);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         seg[0] <= INIT_HEAD;
         seg[1] <= INIT_HEAD - 8'd1;
         for (int unsigned k = 2; k < 16; k++) seg[k] <= '0;
         Length <= 4'd2;
         dir    <= DIR_R;
         Food   <= LFSR_SEED;
         lfsr   <= LFSR_SEED;
      end else begin
         case (state)
            S_FOOD: begin
               lfsr <= lfsr_nxt;
               if (!food_hit) Food <= lfsr_nxt;
            end
            S_PLAY: begin
               dir <= dir_nxt;
               if (Tick && !wall && !self_hit) begin
                  seg[0] <= next_head;
                  for (int unsigned k = 1; k < 16; k++) seg[k] <= seg[k-1];
                  if (eat) Length <= Length + 4'd1;
               end
            end
            // Restart loads the initial snake on the same edge that enters INIT.
            S_WIN, S_LOSE: begin
               if (Start) begin
                  seg[0] <= INIT_HEAD;
                  seg[1] <= INIT_HEAD - 8'd1;
                  for (int unsigned k = 2; k < 16; k++) seg[k] <= '0;
                  Length <= 4'd2;
                  dir    <= DIR_R;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      Locations_Flat = '0;
      for (int unsigned k = 0; k < 16; k++)
         Locations_Flat[127 - 8*k -: 8] = seg[k];
   end

endmodule

// File: tb/tb_snake_engine.sv
// Scoreboard bench for snake_engine: default-length instance plus a WIN_LEN=3 instance on shared stimulus.
// Expectations branch on SNAKE_WRAP_EN where the wall behaviour differs.
module tb_snake_engine;

   logic Clk = 1'b0;
   logic Reset_n = 1'b1;
   logic Start = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0, Tick = 1'b0;

   logic         qi_a, qc_a, qw_a, ql_a, qi_b, qc_b, qw_b, ql_b;
   logic [7:0]   food_a, food_b;
   logic [3:0]   len_a, len_b;
   logic [127:0] flat_a, flat_b;

   localparam int unsigned K_FLAGS = 0, K_LEN = 1, K_FOOD = 2, K_SEG = 3;
   localparam logic [7:0] F_INIT = 8'h08, F_FOOD = 8'h04, F_WIN = 8'h02, F_LOSE = 8'h01, F_PLAY = 8'h00;
   localparam logic [3:0] B_N = 4'b0000, B_U = 4'b1000, B_D = 4'b0100, B_L = 4'b0010, B_R = 4'b0001;

   typedef struct {
      string       name;
      int unsigned dut;
      int unsigned kind;
      int unsigned idx;
      logic [7:0]  exp;
   } exp_t;

   exp_t        sb[$];
   event        sample_ev;
   int unsigned n_checks = 0;
   int unsigned n_err = 0;

   snake_engine #(.WIN_LEN(15), .INIT_HEAD(8'h88), .LFSR_SEED(8'hA5)) dut_a (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
      .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .Tick(Tick),
      .Qi(qi_a), .Qc(qc_a), .Qw(qw_a), .Ql(ql_a),
      .Food(food_a), .Length(len_a), .Locations_Flat(flat_a)
   );

   snake_engine #(.WIN_LEN(3), .INIT_HEAD(8'h88), .LFSR_SEED(8'hA5)) dut_b (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start),
      .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR), .Tick(Tick),
      .Qi(qi_b), .Qc(qc_b), .Qw(qw_b), .Ql(ql_b),
      .Food(food_b), .Length(len_b), .Locations_Flat(flat_b)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] actual(input int unsigned d, input int unsigned kind, input int unsigned k);
      logic [127:0] flat;
      flat = (d == 0) ? flat_a : flat_b;
      case (kind)
         K_FLAGS: return (d == 0) ? {4'b0, qi_a, qc_a, qw_a, ql_a} : {4'b0, qi_b, qc_b, qw_b, ql_b};
         K_LEN:   return (d == 0) ? {4'b0, len_a} : {4'b0, len_b};
         K_FOOD:  return (d == 0) ? food_a : food_b;
         default: return flat[127 - 8*k -: 8];
      endcase
   endfunction

   task automatic push(input string n, input int unsigned d, input int unsigned kind,
                       input int unsigned k, input logic [7:0] v);
      exp_t e;
      e.name = n; e.dut = d; e.kind = kind; e.idx = k; e.exp = v;
      sb.push_back(e);
   endtask

   task automatic chk(input string n, input int unsigned kind, input int unsigned k, input logic [7:0] v);
      push(n, 0, kind, k, v);
   endtask

   task automatic chkb(input string n, input int unsigned kind, input int unsigned k, input logic [7:0] v);
      push(n, 1, kind, k, v);
   endtask

   task automatic cyc(input logic st, input logic [3:0] btn, input logic tk);
      Start = st; {BtnU, BtnD, BtnL, BtnR} = btn; Tick = tk;
      @(posedge Clk); #1;
      Start = 1'b0; {BtnU, BtnD, BtnL, BtnR} = 4'b0; Tick = 1'b0;
   endtask

   task automatic move(input string n, input logic [3:0] btn, input logic [7:0] head);
      cyc(1'b0, btn, 1'b1);
      chk(n, K_SEG, 0, head);
   endtask

   // Monitor: every registered output is stable half a cycle after the edge.
   initial begin
      exp_t e;
      logic [7:0] act;
      forever begin
         @(negedge Clk or sample_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            act = actual(e.dut, e.kind, e.idx);
            n_checks++;
            if (act !== e.exp) begin
               n_err++;
               $display("FAIL %s: dut%0d got %02h expected %02h", e.name, e.dut, act, e.exp);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      #2 Reset_n = 1'b0;
      @(posedge Clk); #1;
      chk("rst_flags", K_FLAGS, 0, F_INIT);
      chk("rst_len", K_LEN, 0, 8'd2);
      chk("rst_food", K_FOOD, 0, 8'hA5);
      chk("rst_seg0", K_SEG, 0, 8'h88);
      chk("rst_seg1", K_SEG, 1, 8'h87);
      chk("rst_seg2", K_SEG, 2, 8'h00);
      chk("rst_seg15", K_SEG, 15, 8'h00);
      chkb("rst_flags_b", K_FLAGS, 0, F_INIT);
      @(posedge Clk); #1 Reset_n = 1'b1;

      cyc(1'b1, B_N, 1'b0);
      chk("start_food", K_FLAGS, 0, F_FOOD);
      cyc(1'b0, B_N, 1'b0);
      chk("food1_flags", K_FLAGS, 0, F_PLAY);
      chk("food1_val", K_FOOD, 0, 8'h4A);
      chk("food1_len", K_LEN, 0, 8'd2);
      chkb("food1_val_b", K_FOOD, 0, 8'h4A);

      cyc(1'b0, B_L, 1'b0);
      move("reverse_ignored", B_N, 8'h89);
      move("right_2", B_N, 8'h8A);
      cyc(1'b0, B_U | B_R, 1'b0);
      move("up_priority", B_N, 8'h7A);
      chk("up_priority_seg1", K_SEG, 1, 8'h8A);
      move("up_2", B_N, 8'h6A);
      move("same_cycle_btn", B_R, 8'h5A);
      cyc(1'b0, B_U, 1'b0);
      move("eat1_head", B_N, 8'h4A);
      chk("eat1_len", K_LEN, 0, 8'd3);
      chk("eat1_flags", K_FLAGS, 0, F_FOOD);
      chk("eat1_seg1", K_SEG, 1, 8'h5A);
      chk("eat1_tail", K_SEG, 2, 8'h6A);
      chkb("win_flags_b", K_FLAGS, 0, F_WIN);
      chkb("win_len_b", K_LEN, 0, 8'd3);

      cyc(1'b0, B_N, 1'b1);
      chk("tick_in_food_flags", K_FLAGS, 0, F_PLAY);
      chk("food2_val", K_FOOD, 0, 8'h95);
      chk("tick_in_food_head", K_SEG, 0, 8'h4A);
      chkb("win_hold_b", K_FLAGS, 0, F_WIN);
      chkb("win_tick_ignored_b", K_SEG, 0, 8'h4A);

      cyc(1'b0, B_L, 1'b0);
      for (int i = 1; i <= 5; i++) move("run_left", B_N, 8'h4A - 8'(i));
      cyc(1'b0, B_D, 1'b0);
      for (int i = 1; i <= 4; i++) move("run_down", B_N, 8'h45 + 8'(16 * i));
      move("eat2_head", B_N, 8'h95);
      chk("eat2_len", K_LEN, 0, 8'd4);
      chk("eat2_flags", K_FLAGS, 0, F_FOOD);
      chk("eat2_tail", K_SEG, 3, 8'h65);
      cyc(1'b0, B_N, 1'b0);
      chk("food3_val", K_FOOD, 0, 8'h2A);

      cyc(1'b0, B_R, 1'b0);
      for (int i = 1; i <= 5; i++) move("run_right", B_N, 8'h95 + 8'(i));
      cyc(1'b0, B_U, 1'b0);
      for (int i = 1; i <= 6; i++) move("run_up", B_N, 8'h9A - 8'(16 * i));
      move("eat3_head", B_N, 8'h2A);
      chk("eat3_len", K_LEN, 0, 8'd5);
      chk("eat3_tail", K_SEG, 4, 8'h6A);
      cyc(1'b0, B_N, 1'b0);
      chk("food4_val", K_FOOD, 0, 8'h54);

      cyc(1'b0, B_R, 1'b0);
      for (int i = 1; i <= 4; i++) move("run_right2", B_N, 8'h2A + 8'(i));
      cyc(1'b0, B_U, 1'b0);
      move("coil_up", B_N, 8'h1E);
      cyc(1'b0, B_L, 1'b0);
      move("coil_left", B_N, 8'h1D);
      cyc(1'b0, B_D, 1'b0);
      cyc(1'b0, B_N, 1'b1);
      chk("self_hit_flags", K_FLAGS, 0, F_LOSE);
      chk("self_hit_head", K_SEG, 0, 8'h1D);
      chk("self_hit_seg3", K_SEG, 3, 8'h2D);
      chk("self_hit_len", K_LEN, 0, 8'd5);

      cyc(1'b1, B_N, 1'b0);
      chk("restart_flags", K_FLAGS, 0, F_INIT);
      chk("restart_len", K_LEN, 0, 8'd2);
      chk("restart_seg0", K_SEG, 0, 8'h88);
      chk("restart_seg1", K_SEG, 1, 8'h87);
      chk("restart_seg2", K_SEG, 2, 8'h00);
      chk("restart_seg4", K_SEG, 4, 8'h00);
      chkb("restart_flags_b", K_FLAGS, 0, F_INIT);
      cyc(1'b1, B_N, 1'b0);
      chk("restart_food_state", K_FLAGS, 0, F_FOOD);
      cyc(1'b0, B_N, 1'b0);
      chk("food5_val", K_FOOD, 0, 8'hA9);
      chkb("food5_val_b", K_FOOD, 0, 8'h95);

      for (int i = 1; i <= 7; i++) move("wall_run", B_N, 8'h88 + 8'(i));
      cyc(1'b0, B_N, 1'b1);
`ifdef SNAKE_WRAP_EN
      chk("edge_flags", K_FLAGS, 0, F_PLAY);
      chk("edge_head", K_SEG, 0, 8'h80);
      chk("edge_seg1", K_SEG, 1, 8'h8F);
      cyc(1'b1, B_N, 1'b0);
      chk("start_in_play", K_FLAGS, 0, F_PLAY);
      Reset_n = 1'b0;
      @(posedge Clk); #1 Reset_n = 1'b1;
`else
      chk("edge_flags", K_FLAGS, 0, F_LOSE);
      chk("edge_head", K_SEG, 0, 8'h8F);
      chk("edge_seg1", K_SEG, 1, 8'h8E);
      cyc(1'b1, B_N, 1'b0);
      chk("lose_restart", K_FLAGS, 0, F_INIT);
`endif
      cyc(1'b0, B_N, 1'b1);
      chk("tick_in_init_flags", K_FLAGS, 0, F_INIT);
      chk("tick_in_init_head", K_SEG, 0, 8'h88);
      cyc(1'b1, B_N, 1'b0);
      chk("pre_reset_food_state", K_FLAGS, 0, F_FOOD);

      #5 Reset_n = 1'b0;
      #1;
      chk("async_rst_flags", K_FLAGS, 0, F_INIT);
      chk("async_rst_food", K_FOOD, 0, 8'hA5);
      chk("async_rst_len", K_LEN, 0, 8'd2);
      chk("async_rst_seg0", K_SEG, 0, 8'h88);
      chkb("async_rst_flags_b", K_FLAGS, 0, F_INIT);
      ->sample_ev;
      repeat (2) @(posedge Clk);
      #1 Reset_n = 1'b1;

      cyc(1'b1, B_N, 1'b0);
      chk("post_rst_food_state", K_FLAGS, 0, F_FOOD);
      cyc(1'b0, B_N, 1'b0);
      chk("post_rst_play", K_FLAGS, 0, F_PLAY);
      chk("post_rst_food_val", K_FOOD, 0, 8'h4A);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge Clk);
      if (sb.size() > 0) begin
         $display("FAIL drain: %0d pending checks got no sample, expected 0", sb.size());
         n_err += sb.size();
         n_checks += sb.size();
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter WIN_LEN, default 15, meaning length at which the game is won (legal range 3..15).
REQ-002 Parameter INIT_HEAD, default 8'h88, meaning head cell index after init (row 8, col 8).
REQ-003 Parameter LFSR_SEED, default 8'hA5, meaning food LFSR value after reset (nonzero).
REQ-004 Clk  in  1  sole clock, all state on rising edge.
REQ-005 Reset_n  in  1  asynchronous, active-low reset.
REQ-006 Start  in  1  level, begin game from INIT or restart from WIN/LOSE.
REQ-007 BtnU, BtnD, BtnL, BtnR  in  1 each  direction requests, level.
REQ-008 Tick  in  1  single-cycle move strobe (slow game rate).
REQ-009 Qi, Qc, Qw, Ql  out  1 each  one-hot state flags: init, food-collect, win, lose.
REQ-010 Food  out  8  food cell index, row*16+col.
REQ-011 Length  out  4  live segment count.
REQ-012 Locations_Flat  out  128  segment k index at bits [127-8k -: 8], k=0 is head.

Function
REQ-013 Grid SHALL be 16x16; cell index = {row[3:0], col[3:0]}.
REQ-014 States SHALL be INIT, FOOD, PLAY, WIN, LOSE; Qi=INIT, Qc=FOOD, Qw=WIN, Ql=LOSE, PLAY drives all flags 0.
REQ-015 INIT: Length=2, seg0=INIT_HEAD, seg1=INIT_HEAD-1, seg2..15=0, dir=RIGHT; Start -> FOOD next cycle.
REQ-016 FOOD: each cycle LFSR (x^8+x^6+x^5+x^4+1, Fibonacci) advances once; if new value matches no segment k<Length, Food<=value, next state PLAY; else remain FOOD.
REQ-017 Cell 0 SHALL never hold food (LFSR never 0); FOOD exits within 255 cycles.
REQ-018 Direction register: priority U>D>L>R among asserted buttons; a request opposite to current dir SHALL be ignored; updates only in PLAY.
REQ-019 Move in PLAY on Tick uses the dir value held before that edge; a same-cycle button takes effect on the next Tick.
REQ-020 Next head = head +/- 1 col or +/- 1 row per dir; exiting the grid SHALL cause LOSE with segments unchanged.
REQ-021 Eat = next head == Food; self-hit = next head equals seg k for 1<=k<=Length-2, or k=Length-1 when eating; self-hit -> LOSE, segments unchanged.
REQ-022 Legal move: seg[k]<=seg[k-1] for k=1..15, seg0<=next head, single cycle.
REQ-023 Eat: Length<=Length+1; if new Length==WIN_LEN -> WIN, else -> FOOD; no eat -> stay PLAY.
REQ-024 Tick outside PLAY and buttons outside PLAY SHALL be ignored.
REQ-025 WIN/LOSE hold all outputs; Start -> INIT next cycle (re-initialising per REQ-015); Start in PLAY or FOOD ignored.
REQ-026 All outputs SHALL be registered; move result visible one cycle after the Tick edge.

Reset
REQ-027 Reset_n low SHALL immediately force INIT with REQ-015 values, Food=LFSR_SEED, LFSR=LFSR_SEED, regardless of state or pending Tick.
REQ-028 Deassertion mid-operation SHALL resume from INIT only; no partial move is retained.

Configuration
REQ-029 Macro SNAKE_WRAP_EN: defined -> grid edges wrap (col 15 right -> col 0, row 0 up -> row 15, etc.), no wall LOSE; undefined -> REQ-020 wall LOSE applies.

Verification
REQ-030 Reset, Start -> Qi then Qc, then PLAY within 255 cycles; Food not in {0x88,0x87}, Length=2.
REQ-031 PLAY from head 0x88 dir RIGHT, 7 Ticks -> head 0x8F; 8th Tick -> Ql=1, head stays 0x8F (with SNAKE_WRAP_EN: head 0x80, no Ql).
REQ-032 Dir RIGHT, BtnL pressed -> ignored, next Tick head+1; BtnU+BtnR same cycle -> UP wins, following Tick head-16.
REQ-033 Force Food=head+1, Tick -> Length 2->3, Qc asserted next cycle, old tail retained as seg2.
REQ-034 Length=5 snake turned U,L,D into own segment 3 -> Ql=1; Start -> Qi, Length=2, head 0x88.
REQ-035 WIN_LEN=3, eat once from Length 2 -> Qw=1, Tick ignored; Reset_n low mid-FOOD -> immediate Qi, Food=0xA5.
